// File: rtl/binary_morph_3x3.sv
// 3x3 binary erosion/dilation on a streamed monochrome image.
// Two line buffers feed a 3x3 window; the result is emitted two cycles after each accepted pixel.
module binary_morph_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter bit MODE      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        binary_vsync,
  input  logic        binary_clken,
  input  logic        binary_data_valid,
  input  logic [23:0] binary_data,
  output logic        morph_vsync,
  output logic        morph_clken,
  output logic        morph_data_valid,
  output logic [23:0] morph_data
);

  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  logic [IMG_WIDTH-1:0] lb1_q;
  logic [IMG_WIDTH-1:0] lb2_q;

  logic          vsync_prev_q, vsync_prev_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [8:0]    win_q, win_d;
  logic          c_ok_q, c_ok_d;
  logic          r_ok_q, r_ok_d;
  logic          beat1_q, beat1_d;
  logic [23:0]   data_q, data_d;
  logic [2:0]    sb1_q, sb1_d;
  logic [2:0]    sb2_q;

  logic          frame_start_s;
  logic          beat_s;
  logic [CW-1:0] col_eff_s;
  logic [1:0]    row_eff_s;
  logic          pix_s;
  logic          lb1_rd_s;
  logic          lb2_rd_s;
  logic          reduce_s;
  logic          unused_data_s;

  assign unused_data_s = ^binary_data[23:1];

  // Counters, window shift and stage-1/stage-2 next-state logic.
  always_comb begin
    frame_start_s = binary_vsync & ~vsync_prev_q;
    beat_s        = binary_clken & binary_data_valid;
    pix_s         = binary_data[0];
    // The beat coinciding with a vsync rise is pixel (0,0) of the new frame.
    if (frame_start_s) begin
      col_eff_s = {CW{1'b0}};
      row_eff_s = 2'd0;
    end else begin
      col_eff_s = col_q;
      row_eff_s = row_q;
    end
    lb1_rd_s     = lb1_q[col_eff_s];
    lb2_rd_s     = lb2_q[col_eff_s];
    vsync_prev_d = binary_vsync;
    col_d        = col_eff_s;
    row_d        = row_eff_s;
    win_d        = win_q;
    c_ok_d       = c_ok_q;
    r_ok_d       = r_ok_q;
    beat1_d      = beat_s;
    sb1_d        = {binary_vsync, binary_clken, binary_data_valid};
    if (beat_s) begin
      if (col_eff_s == COL_LAST) begin
        col_d = {CW{1'b0}};
        row_d = (row_eff_s == 2'd2) ? 2'd2 : (row_eff_s + 2'd1);
      end else begin
        col_d = col_eff_s + {{(CW-1){1'b0}}, 1'b1};
        row_d = row_eff_s;
      end
      // Each 3-bit group is one window row, oldest column in the MSB.
      win_d  = {win_q[7:6], lb2_rd_s, win_q[4:3], lb1_rd_s, win_q[1:0], pix_s};
      c_ok_d = (col_eff_s >= COL_TWO);
      r_ok_d = (row_eff_s == 2'd2);
    end else begin
      win_d = win_q;
    end
    reduce_s = MODE ? (|win_q) : (&win_q);
    data_d   = data_q;
    if (beat1_q) begin
      data_d = (c_ok_q & r_ok_q & reduce_s) ? 24'hFFFFFF : 24'h000000;
    end else begin
      data_d = data_q;
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev_q <= 1'b0;
      col_q        <= {CW{1'b0}};
      row_q        <= 2'd0;
      win_q        <= 9'd0;
      c_ok_q       <= 1'b0;
      r_ok_q       <= 1'b0;
      beat1_q      <= 1'b0;
      data_q       <= 24'd0;
      sb1_q        <= 3'd0;
      sb2_q        <= 3'd0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      c_ok_q       <= c_ok_d;
      r_ok_q       <= r_ok_d;
      beat1_q      <= beat1_d;
      data_q       <= data_d;
      sb1_q        <= sb1_d;
      sb2_q        <= sb1_q;
    end
  end

  // Line buffers are never cleared; row/col gating hides stale contents.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      lb1_q[col_eff_s] <= pix_s;
      lb2_q[col_eff_s] <= lb1_rd_s;
    end
  end

  assign morph_vsync      = sb2_q[2];
  assign morph_clken      = sb2_q[1];
  assign morph_data_valid = sb2_q[0];
  assign morph_data       = data_q;

endmodule

// File: doc/binary_morph_3x3.md
# binary_morph_3x3

3x3 morphological filter (erosion or dilation) on the binary pixel stream produced by the binarization stage; sits directly downstream of it in the grayscale → binary → VDMA pipeline. Buffers two image lines, builds a 3x3 window per accepted pixel, and emits one filtered pixel per input pixel with fixed latency, preserving frame geometry and sideband timing. Used to remove salt noise (erode) or close small gaps (dilate) before write-back.

## Interface
- IMG_WIDTH, 640, pixels per line (line-buffer depth, column wrap point); ≥3
- MODE, 0, 0 = erosion (AND of window), 1 = dilation (OR of window)
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- binary_vsync  in  1  frame sync from binarization stage; rising edge = frame start
- binary_clken  in  1  clock enable from binarization stage
- binary_data_valid  in  1  pixel valid
- binary_data  in  24  replicated monochrome pixel; only bit 0 is used
- morph_vsync  out  1  binary_vsync delayed 2 cycles
- morph_clken  out  1  binary_clken delayed 2 cycles
- morph_data_valid  out  1  binary_data_valid delayed 2 cycles
- morph_data  out  24  filtered pixel replicated to 24 bits (all 1 = white, all 0 = black)

## Operation
- Beat: cycle with binary_clken=1 and binary_data_valid=1. Non-beat cycles change no state except sideband delay lines.
- Column counter col (0..IMG_WIDTH-1): +1 per beat, wraps IMG_WIDTH-1 → 0; on wrap, row flag counter row increments, saturating at 2.
- Frame start: binary_vsync rising edge (registered compare with previous sample) clears col and row. Beat in the same cycle as the rising edge is pixel (0,0) of the new frame.
- Line buffers LB1, LB2: 1 bit × IMG_WIDTH each, addressed by col. On a beat: read LB1[col] (row r-1), LB2[col] (row r-2) returning old contents; write LB2[col] ← LB1[col], LB1[col] ← pixel.
- Window: 3 rows × 3 columns of registers; on a beat shifts left by one column, new column = {LB2[col], LB1[col], pixel}.
- Output for beat at (r,c): if r ≥ 2 and c ≥ 2, reduction (AND for MODE=0, OR for MODE=1) of window covering rows r-2..r, cols c-2..c; otherwise 0. Net effect: filtered image translated by (+1,+1), top two rows and left two columns black; output pixel count equals input count.
- Line buffers are not cleared on vsync or reset; the row/col gating guarantees stale contents never reach morph_data.

## Timing
- Stage 1 (beat cycle +1): window, col≥2 and row≥2 flags registered. Stage 2 (+2): morph_data registered.
- Latency: exactly 2 cycles from input beat to morph_data; sideband outputs delayed 2 cycles unconditionally (every clock, independent of clken/valid).
- morph_data updates only in cycles where the delayed beat qualifier is 1; otherwise holds.
- Reset values: morph_vsync=0, morph_clken=0, morph_data_valid=0, morph_data=0; col=0, row=0, window=0, pipeline qualifiers=0.
- Reset mid-frame: outputs drop to 0 asynchronously; after release the next beat is treated as (0,0).
- vsync rising edge mid-line: counters cleared; in-flight stage 1/2 pixels still complete with their already-computed values.
- Idle gaps between beats (valid or clken low) must not alter results; output stream equals gapless case with gaps preserved.

## Test plan
- IMG_WIDTH=8, MODE=0, all-white 8x4 frame → rows 0–1 all 0; rows 2–3: cols 0–1 = 0, cols 2–7 = 24'hFFFFFF.
- IMG_WIDTH=8, MODE=0, white 8x6 frame with single black pixel at (3,4) → in rows ≥2/cols ≥2 region, outputs 0 exactly at r∈3..5, c∈4..6; all other interior outputs white.
- IMG_WIDTH=8, MODE=1, black 8x6 frame with single white pixel at (2,2) → outputs white exactly at r∈2..4, c∈2..4; all else 0.
- Single beat at cycle t with vsync/clken toggling → morph_data_valid high at t+2 only; morph_vsync/morph_clken equal inputs shifted 2 cycles.
- Repeat test 2 with random 0–3 idle cycles inserted between beats → identical morph_data sequence on valid cycles.
- vsync rise after 10 beats of a frame, then new white frame → first 2·IMG_WIDTH outputs of new frame are 0 regardless of prior data; assert rst mid-frame → all outputs 0 immediately, next frame matches test 1.
